riscv_memreq_queue: RTL and testbench

In-order request queue between the MMU's physical-memory side and the bus interface unit (BIU). It accepts registered physical requests, buffers up to DEPTH outstanding transactions, and issues them to the BIU with a strobe/accept handshake. It returns read data, acknowledges and errors to the requester in issue order. A flush input discards queued work after a pipeline redirect.

---
 rtl/riscv_memreq_queue_if.sv | 51 +++++
 rtl/riscv_memreq_queue.sv | 132 +++++++++++++
 tb/tb_riscv_memreq_queue.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_memreq_queue_if.sv
// Request-side and BIU-side handshake bundle for riscv_memreq_queue.
// The BIU transfer-size type is shared with the queue through riscv_memreq_pkg.
package riscv_memreq_pkg;
  typedef logic [2:0] biu_size_t;
endpackage

interface riscv_memreq_queue_if #(
  parameter int XLEN = 32,
  parameter int PLEN = XLEN
);
  import riscv_memreq_pkg::*;

  logic            flush_i;
  logic            req_i;
  logic [PLEN-1:0] adr_i;
  biu_size_t       size_i;
  logic            lock_i;
  logic            we_i;
  logic [XLEN-1:0] d_i;
  logic            stall_o;
  logic [XLEN-1:0] q_o;
  logic            ack_o;
  logic            err_o;

  logic            biu_stb_o;
  logic            biu_stb_ack_i;
  logic [PLEN-1:0] biu_adr_o;
  biu_size_t       biu_size_o;
  logic            biu_lock_o;
  logic            biu_we_o;
  logic [XLEN-1:0] biu_d_o;
  logic [XLEN-1:0] biu_q_i;
  logic            biu_ack_i;
  logic            biu_err_i;

  // Queue-side view.
  modport slave (
    input  flush_i, req_i, adr_i, size_i, lock_i, we_i, d_i,
    input  biu_stb_ack_i, biu_q_i, biu_ack_i, biu_err_i,
    output stall_o, q_o, ack_o, err_o,
    output biu_stb_o, biu_adr_o, biu_size_o, biu_lock_o, biu_we_o, biu_d_o
  );

  // Requester/BIU-side view.
  modport master (
    output flush_i, req_i, adr_i, size_i, lock_i, we_i, d_i,
    output biu_stb_ack_i, biu_q_i, biu_ack_i, biu_err_i,
    input  stall_o, q_o, ack_o, err_o,
    input  biu_stb_o, biu_adr_o, biu_size_o, biu_lock_o, biu_we_o, biu_d_o
  );
endinterface

// File: rtl/riscv_memreq_queue.sv
// In-order physical memory request queue between the MMU and the BIU, with flush.
// Optional feature: define RV_MEMQ_BYPASS_EN for a zero-latency path when the FIFO is empty.
module riscv_memreq_queue
  import riscv_memreq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PLEN  = XLEN,
  parameter int DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  riscv_memreq_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PLEN-1:0] adr;
    biu_size_t       size;
    logic            lock;
    logic            we;
    logic [XLEN-1:0] d;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        req_ent;
  entry_t        head_ent;
  entry_t        biu_ent;

  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] queued;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;

  logic          stall;
  logic          has_q;
  logic          push;
  logic          wr_en;
  logic          stb;
  logic          accept;
  logic          pop;
  logic          done;
  logic          rsp_vld_p0;

  assign req_ent  = {bus.adr_i, bus.size_i, bus.lock_i, bus.we_i, bus.d_i};
  assign head_ent = mem[rd_ptr[AW-1:0]];

  // Full is judged on registered counters only, so a same-cycle pop never frees a slot.
  assign stall = (queued + inflight) == CW'(DEPTH);
  assign has_q = (queued != '0);
  assign push  = bus.req_i && !stall && !bus.flush_i;

  // Responses arriving with nothing outstanding (e.g. after reset) are dropped.
  assign done       = (bus.biu_ack_i || bus.biu_err_i) && (inflight != '0);
  assign rsp_vld_p0 = done && (discard == '0) && !bus.flush_i;

`ifdef RV_MEMQ_BYPASS_EN
  logic byp_offer;
  logic byp_take;

  // Empty FIFO: offer the incoming request straight to the BIU; it lands in the FIFO only if not taken.
  assign byp_offer = !has_q && push && rst_ni;
  assign byp_take  = byp_offer && bus.biu_stb_ack_i;
  assign stb       = (has_q && !bus.flush_i) || byp_offer;
  assign biu_ent   = has_q ? head_ent : (byp_offer ? req_ent : '0);
  assign accept    = stb && bus.biu_stb_ack_i;
  assign pop       = accept && has_q;
  assign wr_en     = push && !byp_take;
`else
  assign stb     = has_q && !bus.flush_i;
  assign biu_ent = has_q ? head_ent : '0;
  assign accept  = stb && bus.biu_stb_ack_i;
  assign pop     = accept;
  assign wr_en   = push;
`endif

  assign bus.biu_stb_o  = stb;
  assign bus.biu_adr_o  = biu_ent.adr;
  assign bus.biu_size_o = biu_ent.size;
  assign bus.biu_lock_o = biu_ent.lock;
  assign bus.biu_we_o   = biu_ent.we;
  assign bus.biu_d_o    = biu_ent.d;
  assign bus.stall_o    = stall;

  // Storage stage: entry data is not reset, only the pointers that qualify it.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= req_ent;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      queued   <= '0;
      inflight <= '0;
      discard  <= '0;
    end else begin
      rd_ptr   <= rd_ptr + CW'(pop);
      inflight <= inflight + CW'(accept) - CW'(done);
      if (bus.flush_i) begin
        wr_ptr  <= rd_ptr;
        queued  <= '0;
        // Everything still outstanding after this cycle completes silently.
        discard <= inflight - CW'(done);
      end else begin
        wr_ptr <= wr_ptr + CW'(wr_en);
        queued <= queued + CW'(wr_en) - CW'(pop);
        if (done && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  // Response stage: one-cycle registered report of a BIU completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.ack_o <= 1'b0;
      bus.err_o <= 1'b0;
      bus.q_o   <= '0;
    end else begin
      bus.ack_o <= rsp_vld_p0 && bus.biu_ack_i;
      bus.err_o <= rsp_vld_p0 && bus.biu_err_i;
      if (rsp_vld_p0) bus.q_o <= bus.biu_err_i ? '0 : bus.biu_q_i;
    end
  end

  ack_err_exclusive: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(bus.biu_ack_i && bus.biu_err_i));

  occupancy_bound: assert property (
    @(posedge clk_i) disable iff (!rst_ni) (queued + inflight) <= CW'(DEPTH));
endmodule

// File: tb/tb_riscv_memreq_queue.sv
// Randomized and directed bench for riscv_memreq_queue against a queue-based reference model.
module tb_riscv_memreq_queue;
  import riscv_memreq_pkg::*;

  localparam int XLEN  = 32;
  localparam int PLEN  = 32;
  localparam int DEPTH = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  riscv_memreq_queue_if #(.XLEN(XLEN), .PLEN(PLEN)) bus ();

  riscv_memreq_queue #(.XLEN(XLEN), .PLEN(PLEN), .DEPTH(DEPTH)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_ack = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // BIU side: directed values, or a random responder when auto_biu is set.
  bit              auto_biu = 1'b0;
  int              acc_pct  = 50;
  int              rsp_pct  = 50;
  int              err_pct  = 0;
  int              biu_out  = 0;
  logic            r_stb_ack = 1'b0, r_ack = 1'b0, r_err = 1'b0;
  logic [XLEN-1:0] r_q = '0;
  logic            d_stb_ack = 1'b0, d_ack = 1'b0, d_err = 1'b0;
  logic [XLEN-1:0] d_q = '0;

  assign bus.biu_stb_ack_i = auto_biu ? r_stb_ack : d_stb_ack;
  assign bus.biu_ack_i     = auto_biu ? r_ack     : d_ack;
  assign bus.biu_err_i     = auto_biu ? r_err     : d_err;
  assign bus.biu_q_i       = auto_biu ? r_q       : d_q;

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) biu_out = 0;
      else begin
        if (bus.biu_stb_o && bus.biu_stb_ack_i) biu_out++;
        if ((bus.biu_ack_i || bus.biu_err_i) && biu_out > 0) biu_out--;
      end
      @(posedge clk_i);
      #1;
      r_stb_ack = auto_biu && ($urandom_range(0, 99) < acc_pct);
      r_ack = 1'b0;
      r_err = 1'b0;
      if (auto_biu && biu_out > 0 && $urandom_range(0, 99) < rsp_pct) begin
        if ($urandom_range(0, 99) < err_pct) r_err = 1'b1;
        else r_ack = 1'b1;
        r_q = $urandom;
      end
    end
  end

  // Reference model: requests waiting for issue, and issued requests awaiting completion.
  typedef struct {
    logic [PLEN-1:0] adr;
    biu_size_t       size;
    logic            lock;
    logic            we;
    logic [XLEN-1:0] d;
  } req_t;

  typedef struct {
    req_t r;
    bit   disc;
  } fl_t;

  req_t            pend[$];
  fl_t             infl[$];
  logic            exp_ack = 1'b0, exp_err = 1'b0;
  logic [XLEN-1:0] exp_q = '0;

  initial begin
    bit   m_stall, m_stb, m_push, m_acc, m_done;
    fl_t  c;
    req_t nr;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        pend.delete();
        infl.delete();
        exp_ack = 1'b0;
        exp_err = 1'b0;
        exp_q   = '0;
      end else begin
        m_stall = (pend.size() + infl.size()) == DEPTH;
        m_stb   = (pend.size() != 0) && !bus.flush_i;
        chk("stall_o", bus.stall_o, m_stall);
        chk("biu_stb_o", bus.biu_stb_o, m_stb);
        if (m_stb) begin
          chk("biu_adr_o", bus.biu_adr_o, pend[0].adr);
          chk("biu_size_o", bus.biu_size_o, pend[0].size);
          chk("biu_lock_o", bus.biu_lock_o, pend[0].lock);
          chk("biu_we_o", bus.biu_we_o, pend[0].we);
          chk("biu_d_o", bus.biu_d_o, pend[0].d);
        end
        chk("ack_o", bus.ack_o, exp_ack);
        chk("err_o", bus.err_o, exp_err);
        chk("q_o", bus.q_o, exp_q);
        if (bus.ack_o) n_ack++;

        m_push  = bus.req_i && !m_stall && !bus.flush_i;
        m_acc   = m_stb && bus.biu_stb_ack_i;
        m_done  = (bus.biu_ack_i || bus.biu_err_i) && (infl.size() != 0);
        exp_ack = 1'b0;
        exp_err = 1'b0;
        if (m_done) begin
          c = infl.pop_front();
          if (!c.disc && !bus.flush_i) begin
            exp_ack = bus.biu_ack_i;
            exp_err = bus.biu_err_i;
            exp_q   = bus.biu_err_i ? '0 : bus.biu_q_i;
          end
        end
        if (bus.flush_i) begin
          foreach (infl[i]) infl[i].disc = 1'b1;
          pend.delete();
        end
        if (m_acc) begin
          c.r    = pend.pop_front();
          c.disc = 1'b0;
          infl.push_back(c);
        end
        if (m_push) begin
          nr.adr  = bus.adr_i;
          nr.size = bus.size_i;
          nr.lock = bus.lock_i;
          nr.we   = bus.we_i;
          nr.d    = bus.d_i;
          pend.push_back(nr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic r, input logic [PLEN-1:0] a, input logic w,
                         input logic [XLEN-1:0] d);
    bus.req_i  = r;
    bus.adr_i  = a;
    bus.we_i   = w;
    bus.d_i    = d;
    bus.size_i = 3'd2;
    bus.lock_i = 1'b0;
  endtask

  task automatic drain();
    auto_biu = 1'b1;
    acc_pct  = 100;
    rsp_pct  = 100;
    err_pct  = 0;
    for (int i = 0; i < 200 && (pend.size() != 0 || infl.size() != 0); i++) tick();
    chk("drain_empty", pend.size() + infl.size(), 0);
    auto_biu = 1'b0;
    tick();
  endtask

  task automatic xfer_read(input logic [PLEN-1:0] a, input logic e,
                           input logic [XLEN-1:0] qd, input string nm);
    set_req(1'b1, a, 1'b0, '0);
    tick();
    set_req(1'b0, '0, 1'b0, '0);
    chk({nm, "_adr"}, bus.biu_adr_o, a);
    d_stb_ack = 1'b1;
    tick();
    d_stb_ack = 1'b0;
    d_q = qd;
    if (e) d_err = 1'b1;
    else d_ack = 1'b1;
    tick();
    d_ack = 1'b0;
    d_err = 1'b0;
    chk({nm, "_ack"}, bus.ack_o, !e);
    chk({nm, "_err"}, bus.err_o, e);
    chk({nm, "_q"}, bus.q_o, e ? 32'h0 : qd);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int guard;
    int base;
    bus.flush_i = 1'b0;
    set_req(1'b0, '0, 1'b0, '0);

    repeat (3) tick();
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_stb", bus.biu_stb_o, 0);
    chk("rst_ack", bus.ack_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_q", bus.q_o, 0);
    chk("rst_adr", bus.biu_adr_o, 0);
    rst_ni = 1'b1;
    tick();

    // Single read.
    set_req(1'b1, 32'h100, 1'b0, '0);
    tick();
    set_req(1'b0, '0, 1'b0, '0);
    chk("rd_stb", bus.biu_stb_o, 1);
    chk("rd_adr", bus.biu_adr_o, 32'h100);
    d_stb_ack = 1'b1;
    tick();
    d_stb_ack = 1'b0;
    chk("rd_stb_drop", bus.biu_stb_o, 0);
    d_ack = 1'b1;
    d_q   = 32'hDEADBEEF;
    tick();
    d_ack = 1'b0;
    chk("rd_ack", bus.ack_o, 1);
    chk("rd_q", bus.q_o, 32'hDEADBEEF);
    tick();
    chk("rd_ack_pulse", bus.ack_o, 0);
    chk("rd_q_hold", bus.q_o, 32'hDEADBEEF);

    // Full queue.
    set_req(1'b1, 32'h200, 1'b1, 32'hA);
    tick();
    set_req(1'b1, 32'h204, 1'b1, 32'hB);
    tick();
    set_req(1'b1, 32'h208, 1'b1, 32'hC);
    chk("full_stall", bus.stall_o, 1);
    tick();
    chk("full_stall_hold", bus.stall_o, 1);
    chk("full_head", bus.biu_adr_o, 32'h200);
    d_stb_ack = 1'b1;
    tick();
    d_stb_ack = 1'b0;
    chk("full_stall_inflight", bus.stall_o, 1);
    d_ack = 1'b1;
    tick();
    d_ack = 1'b0;
    chk("full_release", bus.stall_o, 0);
    chk("full_ack", bus.ack_o, 1);
    tick();
    set_req(1'b0, '0, 1'b0, '0);
    chk("full_third_in", bus.stall_o, 1);
    chk("full_next_head", bus.biu_adr_o, 32'h204);
    drain();

    // Order and wrap with random BIU timing.
    auto_biu = 1'b1;
    acc_pct  = 50;
    rsp_pct  = 40;
    err_pct  = 0;
    base     = n_ack;
    k        = 0;
    guard    = 0;
    while (k < 8 && guard < 500) begin
      set_req(1'b1, 32'h1000 + 32'(4 * k), 1'b1, $urandom);
      if (!bus.stall_o) k++;
      tick();
      guard++;
    end
    set_req(1'b0, '0, 1'b0, '0);
    chk("wrap_pushed", k, 8);
    drain();
    chk("wrap_acks", n_ack - base, 8);

    // Error on the middle of three reads.
    xfer_read(32'h300, 1'b0, 32'h11111111, "err_r1");
    xfer_read(32'h304, 1'b1, 32'hBADBAD00, "err_r2");
    xfer_read(32'h308, 1'b0, 32'h33333333, "err_r3");

    // Flush with one in flight and one queued.
    set_req(1'b1, 32'h400, 1'b0, '0);
    tick();
    set_req(1'b0, '0, 1'b0, '0);
    d_stb_ack = 1'b1;
    tick();
    d_stb_ack = 1'b0;
    set_req(1'b1, 32'h404, 1'b0, '0);
    tick();
    set_req(1'b0, '0, 1'b0, '0);
    chk("fl_stb_before", bus.biu_stb_o, 1);
    chk("fl_adr", bus.biu_adr_o, 32'h404);
    bus.flush_i = 1'b1;
    #1;
    chk("fl_stb_low", bus.biu_stb_o, 0);
    tick();
    bus.flush_i = 1'b0;
    #1;
    chk("fl_dropped", bus.biu_stb_o, 0);
    repeat (2) tick();
    chk("fl_never_issued", bus.biu_stb_o, 0);
    d_ack = 1'b1;
    d_q   = 32'h55555555;
    tick();
    d_ack = 1'b0;
    chk("fl_no_ack", bus.ack_o, 0);
    chk("fl_q_hold", bus.q_o, 32'h33333333);
    xfer_read(32'h500, 1'b0, 32'h66666666, "fl_new");

    // Reset mid-transfer with two entries queued.
    set_req(1'b1, 32'h600, 1'b1, 32'h77);
    tick();
    set_req(1'b1, 32'h604, 1'b1, 32'h78);
    tick();
    set_req(1'b0, '0, 1'b0, '0);
    chk("rm_stb_before", bus.biu_stb_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rm_stall", bus.stall_o, 0);
    chk("rm_stb", bus.biu_stb_o, 0);
    chk("rm_ack", bus.ack_o, 0);
    chk("rm_err", bus.err_o, 0);
    chk("rm_q", bus.q_o, 0);
    chk("rm_adr", bus.biu_adr_o, 0);
    chk("rm_we", bus.biu_we_o, 0);
    chk("rm_d", bus.biu_d_o, 0);
    repeat (2) tick();
    rst_ni = 1'b1;
    #1;
    chk("rm_post_stall", bus.stall_o, 0);
    chk("rm_post_stb", bus.biu_stb_o, 0);
    tick();
    chk("rm_post_stb2", bus.biu_stb_o, 0);

    // Randomized traffic with errors and occasional flushes.
    auto_biu = 1'b1;
    acc_pct  = 50;
    rsp_pct  = 50;
    err_pct  = 20;
    repeat (3000) begin
      bus.req_i   = ($urandom_range(0, 99) < 60);
      bus.adr_i   = $urandom;
      bus.size_i  = biu_size_t'($urandom_range(0, 7));
      bus.lock_i  = 1'($urandom_range(0, 1));
      bus.we_i    = 1'($urandom_range(0, 1));
      bus.d_i     = $urandom;
      bus.flush_i = ($urandom_range(0, 99) < 3);
      tick();
    end
    set_req(1'b0, '0, 1'b0, '0);
    bus.flush_i = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
